// File: rtl/cfg_chain_pkg.sv
// Shared definitions for the configuration-chain controller.
//   chainState_t : controller state encoding
//   CRC_POLY     : CRC-16-CCITT polynomial, MSB-first, no reflection
//   CRC_INIT     : CRC seed loaded at the start of every frame
//   crc16_step() : reference CRC update over the low nbits of data,
//                  MSB first; data wider than a word is zero-padded
package cfg_chain_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    CHECK    = 3'd2,
    COMMIT   = 3'd3,
    READBACK = 3'd4
  } chainState_t;

  localparam logic [15:0] CRC_POLY  = 16'h1021;
  localparam logic [15:0] CRC_INIT  = 16'hFFFF;
  localparam int          CRC_MAX_W = 1024;

  // Bit-serial CRC update over the low nbits of data, most significant
  // bit first. Bits at or above nbits are skipped entirely.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic [CRC_MAX_W-1:0] data,
                                             input int nbits);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = CRC_MAX_W - 1; i >= 0; i--) begin
      if (i < nbits) begin
        fb = c[15] ^ data[i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ CRC_POLY;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/cfg_chain_ctrl_crc16.sv
// Registered CRC-16-CCITT accumulator for one WIDTH-bit word per cycle.
//   clk      : clock
//   res      : asynchronous active-high reset, seeds the register
//   i_clear  : reseed to CRC_INIT (takes priority over i_enable)
//   i_enable : fold i_data into the running CRC
//   i_data   : word to fold in, processed MSB first
//   o_crc    : current CRC register value
module cfg_crc16
  import cfg_chain_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             res,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_data,
  output logic [15:0]      o_crc
);

  logic [15:0] r_crc;
  logic [15:0] w_next;

  // Unrolled bit-serial update: every data bit, MSB first, shifts the
  // CRC left and folds in the polynomial when the outgoing bit differs
  // from the data bit. The whole word is absorbed in a single cycle.
  always_comb begin
    w_next = r_crc;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      w_next = {w_next[14:0], 1'b0} ^ ((w_next[15] ^ i_data[i]) ? CRC_POLY : 16'h0000);
    end
  end

  // CRC register: reseeded at frame start, advanced only on accepted
  // data words so idle cycles leave it untouched.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_crc <= CRC_INIT;
    end else if (i_clear) begin
      r_crc <= CRC_INIT;
    end else if (i_enable) begin
      r_crc <= w_next;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/cfg_chain_ctrl.sv
// Configuration-chain controller: streams WORDS x WIDTH words into a
// shift chain, optionally verifies a CRC-16 trailer, then commits the
// chain into a shadow image that drives cfg_o. Readback rotates the
// chain once round so its contents are unchanged afterwards.
//   clk, res      : clock, asynchronous active-high reset
//   start         : begin a load frame (honoured only in IDLE)
//   rb_start      : begin readback (honoured only in IDLE, start wins)
//   prog_i        : configuration / CRC trailer word in
//   prog_valid    : prog_i valid
//   prog_ready    : controller accepts prog_i (LOAD and CHECK)
//   prog_o        : chain tail word, chain[WORDS-1]
//   prog_o_valid  : prog_o is shifted out this cycle
//   cfg_o         : committed shadow image, word k at [k*WIDTH +: WIDTH]
//   cfg_valid     : shadow holds a committed image
//   busy          : controller is not IDLE
//   err           : sticky CRC mismatch, cleared by the next start
module cfg_chain_ctrl
  import cfg_chain_pkg::*;
#(
  parameter int WORDS  = 83,
  parameter int WIDTH  = 32,
  parameter bit CRC_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   start,
  input  logic                   rb_start,
  input  logic [WIDTH-1:0]       prog_i,
  input  logic                   prog_valid,
  output logic                   prog_ready,
  output logic [WIDTH-1:0]       prog_o,
  output logic                   prog_o_valid,
  output logic [WORDS*WIDTH-1:0] cfg_o,
  output logic                   cfg_valid,
  output logic                   busy,
  output logic                   err
);

  localparam int               CNT_W    = $clog2(WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

  chainState_t            r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [WIDTH-1:0]       r_chain [WORDS];
  logic [WORDS*WIDTH-1:0] r_shadow;
  logic                   r_cfgValid;
  logic                   r_err;
  logic                   r_progReady;
  logic                   r_busy;

  logic                   w_loadXfer;
  logic                   w_shift;
  logic                   w_crcClear;
  logic [15:0]            w_crc;
  logic [WORDS*WIDTH-1:0] w_chainFlat;

  // A data word moves into the chain only in LOAD with a handshake; in
  // READBACK the chain rotates every cycle with no backpressure.
  assign w_loadXfer = (r_state == LOAD) & prog_valid & r_progReady;
  assign w_shift    = w_loadXfer | (r_state == READBACK);
  assign w_crcClear = (r_state == IDLE) & start;

  cfg_crc16 #(
    .WIDTH (WIDTH)
  ) u_crc (
    .clk      (clk),
    .res      (res),
    .i_clear  (w_crcClear),
    .i_enable (w_loadXfer),
    .i_data   (prog_i),
    .o_crc    (w_crc)
  );

  // Flatten the chain so a commit can copy it into the shadow in one go.
  always_comb begin
    w_chainFlat = '0;
    for (int k = 0; k < WORDS; k++) begin
      w_chainFlat[k*WIDTH +: WIDTH] = r_chain[k];
    end
  end

  // Shift chain: a load pushes prog_i into word 0, readback feeds the
  // tail back into word 0 so WORDS rotations restore the original order.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int k = 0; k < WORDS; k++) begin
        r_chain[k] <= '0;
      end
    end else if (w_shift) begin
      r_chain[0] <= w_loadXfer ? prog_i : r_chain[WORDS-1];
      for (int k = 1; k < WORDS; k++) begin
        r_chain[k] <= r_chain[k-1];
      end
    end
  end

  // Control FSM. prog_ready and busy are registered alongside the state
  // so they depend on state alone. The shadow only changes in COMMIT,
  // so a CRC failure or a reset mid-frame never exposes a partial image.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_cfgValid  <= 1'b0;
      r_shadow    <= '0;
      r_progReady <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= LOAD;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_progReady <= 1'b1;
            r_busy      <= 1'b1;
          end else if (rb_start) begin
            r_state <= READBACK;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (prog_valid) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
              if (CRC_EN) begin
                r_state <= CHECK;
              end else begin
                r_state     <= COMMIT;
                r_progReady <= 1'b0;
              end
            end
          end
        end
        CHECK: begin
          if (prog_valid) begin
            r_progReady <= 1'b0;
            if (prog_i[15:0] == w_crc) begin
              r_state <= COMMIT;
            end else begin
              r_err   <= 1'b1;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        COMMIT: begin
          r_shadow   <= w_chainFlat;
          r_cfgValid <= 1'b1;
          r_state    <= IDLE;
          r_busy     <= 1'b0;
        end
        READBACK: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_progReady <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign prog_ready   = r_progReady;
  assign prog_o       = r_chain[WORDS-1];
  assign prog_o_valid = w_shift;
  assign cfg_o        = r_shadow;
  assign cfg_valid    = r_cfgValid;
  assign busy         = r_busy;
  assign err          = r_err;

endmodule
